// File: rtl/scc_pkg.sv
// Shared encodings for the SCC decode/register-file/execute slice.
// Instruction classes, sub-op enums and field positions live here.
package scc_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 8;
    localparam int RAW   = 3;

    localparam int CLS_HI = 31;
    localparam int CLS_LO = 29;
    localparam int SUB_HI = 28;
    localparam int SUB_LO = 25;
    localparam int IR_BIT = 30;
    localparam int RD_HI  = 24;
    localparam int RD_LO  = 22;
    localparam int RN_HI  = 21;
    localparam int RN_LO  = 19;
    localparam int RM_HI  = 18;
    localparam int RM_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        CLS_MOVE = 3'b000,
        CLS_ALUI = 3'b001,
        CLS_ALUR = 3'b011
    } cls_e;

    typedef enum logic [3:0] {
        MV_MOV  = 4'd0,
        MV_MOVT = 4'd1,
        MV_CLR  = 4'd2,
        MV_SET  = 4'd3
    } mv_op_e;

    typedef enum logic [2:0] {
        ALU_NOP0 = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_NOT  = 3'd6,
        ALU_NOP7 = 3'd7
    } alu_oc_e;

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/scc_regfile.sv
// 8x32 register file: async clear, three combinational reads, one write.
// Reads return the committed value; a write lands on the rising edge.
module scc_regfile
    import scc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [RAW-1:0]  i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [RAW-1:0]  i_raddr1,
    input  logic [RAW-1:0]  i_raddr2,
    input  logic [RAW-1:0]  i_raddr3,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    output logic [XLEN-1:0] o_rdata3
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];
    assign o_rdata3 = r_mem[i_raddr3];

endmodule

// File: rtl/scc_datapath.sv
// Single-cycle decode, operand read, execute and write-back select.
// The result commits to the register file on the next rising edge.
module scc_datapath
    import scc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instruction,
    input  logic [2:0]      dbg_addr,
    output logic [31:0]     dbg_data,
    output logic            wb_en,
    output logic [2:0]      wb_addr,
    output logic [31:0]     wb_data
);

    logic [2:0]      w_class;
    logic [3:0]      w_sub_op;
    logic [2:0]      w_alu_oc;
    logic            w_ir_op;
    logic [RAW-1:0]  w_rd;
    logic [RAW-1:0]  w_rn;
    logic [RAW-1:0]  w_rm;
    logic [15:0]     w_imm16;

    logic            w_is_move;
    logic            w_is_alu;
    logic            w_is_movt;
    logic [RAW-1:0]  w_raddr1;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;
    logic [XLEN-1:0] w_operand;

    logic [XLEN-1:0] w_mov_data;
    logic            w_mov_valid;
    logic [XLEN-1:0] w_alu_res;
    logic            w_alu_valid;
    logic            w_write_data_sel;
    logic            w_wb_en;
    logic [XLEN-1:0] w_wb_data;

    assign w_class  = instruction[CLS_HI:CLS_LO];
    assign w_sub_op = instruction[SUB_HI:SUB_LO];
    assign w_alu_oc = instruction[SUB_LO+2:SUB_LO];
    assign w_ir_op  = instruction[IR_BIT];
    assign w_rd     = instruction[RD_HI:RD_LO];
    assign w_rn     = instruction[RN_HI:RN_LO];
    assign w_rm     = instruction[RM_HI:RM_LO];
    assign w_imm16  = instruction[IMM_HI:IMM_LO];

    assign w_is_move = (w_class == CLS_MOVE);
    assign w_is_alu  = (w_class == CLS_ALUI) ||
                       (w_class == CLS_ALUR);
    assign w_is_movt = w_is_move && (w_sub_op == MV_MOVT);

    // MOVT keeps the low half of Rd, so port 1 reads Rd instead of Rn.
    assign w_raddr1 = w_is_movt ? w_rd : w_rn;

    scc_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_wb_en),
        .i_waddr  (w_rd),
        .i_wdata  (w_wb_data),
        .i_raddr1 (w_raddr1),
        .i_raddr2 (w_rm),
        .i_raddr3 (dbg_addr),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .o_rdata3 (dbg_data)
    );

    assign w_operand = w_ir_op ? w_rdata2 : zext16(w_imm16);

    always_comb begin
        w_mov_data  = '0;
        w_mov_valid = 1'b0;
        case (w_sub_op)
            MV_MOV: begin
                w_mov_data  = zext16(w_imm16);
                w_mov_valid = 1'b1;
            end
            MV_MOVT: begin
                w_mov_data  = {w_imm16, w_rdata1[15:0]};
                w_mov_valid = 1'b1;
            end
            MV_CLR: begin
                w_mov_data  = '0;
                w_mov_valid = 1'b1;
            end
            MV_SET: begin
                w_mov_data  = '1;
                w_mov_valid = 1'b1;
            end
            default: begin
                w_mov_data  = '0;
                w_mov_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_alu_res   = '0;
        w_alu_valid = 1'b1;
        case (w_alu_oc)
            ALU_ADD: w_alu_res = w_rdata1 + w_operand;
            ALU_SUB: w_alu_res = w_rdata1 - w_operand;
            ALU_AND: w_alu_res = w_rdata1 & w_operand;
            ALU_OR:  w_alu_res = w_rdata1 | w_operand;
            ALU_XOR: w_alu_res = w_rdata1 ^ w_operand;
            ALU_NOT: w_alu_res = ~w_rdata1;
            default: begin
                w_alu_res   = '0;
                w_alu_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_wb_en          = 1'b0;
        w_write_data_sel = 1'b0;
        unique case (1'b1)
            w_is_move: begin
                w_wb_en          = w_mov_valid;
                w_write_data_sel = 1'b0;
            end
            w_is_alu: begin
                w_wb_en          = w_alu_valid;
                w_write_data_sel = 1'b1;
            end
            default: begin
                w_wb_en          = 1'b0;
                w_write_data_sel = 1'b0;
            end
        endcase
    end

    assign w_wb_data = w_write_data_sel ? w_alu_res : w_mov_data;

    assign wb_en   = w_wb_en;
    assign wb_addr = w_rd;
    assign wb_data = w_wb_data;

endmodule

// File: tb/tb_scc_datapath.sv
// Directed bench for scc_datapath: moves, ALU ops, wrap, NOPs, reset.
// Expected values are hand-computed from the instruction encodings.
module tb_scc_datapath;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;

    int n_checks;
    int n_fail;

    scc_datapath dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic exec(input logic [31:0] ins);
        instruction = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            n_checks++;
            if (v !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_R%0d: got %h expected %h", i, v, 32'h0);
            end
        end
        instruction = 32'hE000_0000;
        #1;
        n_checks++;
        if (wb_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nop_wb_en: got %b expected 0", wb_en);
        end
    endtask

    task automatic test_move();
        logic [31:0] v;
        exec(32'h0000_FFFF);
        rd(3'd0, v);
        n_checks++;
        if (v !== 32'h0000_FFFF) begin
            n_fail++;
            $display("FAIL mov_R0: got %h expected %h", v, 32'h0000_FFFF);
        end
        instruction = 32'h0200_EEEE;
        #1;
        n_checks++;
        if (wb_en !== 1'b1 || wb_addr !== 3'd0 || wb_data !== 32'hEEEE_FFFF) begin
            n_fail++;
            $display("FAIL movt_wb: got en=%b addr=%0d data=%h expected en=1 addr=0 data=eeeeffff",
                     wb_en, wb_addr, wb_data);
        end
        exec(32'h0200_EEEE);
        rd(3'd0, v);
        n_checks++;
        if (v !== 32'hEEEE_FFFF) begin
            n_fail++;
            $display("FAIL movt_R0: got %h expected %h", v, 32'hEEEE_FFFF);
        end
        exec(32'h0640_0000);
        rd(3'd1, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL set_R1: got %h expected %h", v, 32'hFFFF_FFFF);
        end
        exec(32'h0680_0000);
        exec(32'h0480_0000);
        rd(3'd2, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL clr_R2: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_clr_all();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) begin
            exec(32'h0400_0000 | (32'(i) << 22));
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            n_checks++;
            if (v !== 32'h0) begin
                n_fail++;
                $display("FAIL clr_all_R%0d: got %h expected %h", i, v, 32'h0);
            end
        end
    endtask

    task automatic test_add_sub();
        logic [31:0] ins [5];
        logic [2:0]  dst [5];
        logic [31:0] exp [5];
        logic [31:0] v;
        ins = '{32'h0040_0001, 32'h2200_0001, 32'h6201_0000,
                32'h2400_0001, 32'h6400_0000};
        dst = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        exp = '{32'h1, 32'h1, 32'h2, 32'h1, 32'h0};
        for (int i = 0; i < 5; i++) begin
            exec(ins[i]);
            rd(dst[i], v);
            n_checks++;
            if (v !== exp[i]) begin
                n_fail++;
                $display("FAIL addsub_%0d ins=%h: got %h expected %h", i, ins[i], v, exp[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [31:0] ins [10];
        logic [2:0]  dst [10];
        logic [31:0] exp [10];
        logic [31:0] v;
        ins = '{32'h0000_000F, 32'h2600_0006, 32'h0040_0002, 32'h7601_0000,
                32'h2800_000F, 32'h2840_0010, 32'h6841_0000, 32'h6A01_0000,
                32'h2A00_000F, 32'h6C00_0000};
        dst = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
        exp = '{32'hF, 32'h6, 32'h2, 32'h2, 32'hF, 32'h1F, 32'h1F, 32'h10,
                32'h1F, 32'hFFFF_FFE0};
        for (int i = 0; i < 10; i++) begin
            exec(ins[i]);
            rd(dst[i], v);
            n_checks++;
            if (v !== exp[i]) begin
                n_fail++;
                $display("FAIL logic_%0d ins=%h: got %h expected %h", i, ins[i], v, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        exec(32'h0680_0000);
        exec(32'h2290_0001);
        rd(3'd2, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_add: got %h expected %h", v, 32'h0);
        end
        exec(32'h2490_0001);
        rd(3'd2, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_sub: got %h expected %h", v, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_nop();
        logic [31:0] ins [5];
        logic [31:0] exp [8];
        logic [31:0] v;
        ins = '{32'hE000_0000, 32'h4000_0000, 32'h2000_0001,
                32'h2E00_0001, 32'h0800_1234};
        exp = '{32'hFFFF_FFE0, 32'h1F, 32'hFFFF_FFFF, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0};
        for (int k = 0; k < 5; k++) begin
            instruction = ins[k];
            #1;
            n_checks++;
            if (wb_en !== 1'b0) begin
                n_fail++;
                $display("FAIL nop_wb_en ins=%h: got %b expected 0", ins[k], wb_en);
            end
            exec(ins[k]);
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            n_checks++;
            if (v !== exp[i]) begin
                n_fail++;
                $display("FAIL nop_R%0d: got %h expected %h", i, v, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        exec(32'h0000_0005);
        instruction = 32'h2200_0003;
        dbg_addr = 3'd0;
        #1;
        n_checks++;
        if (dbg_data !== 32'h5 || wb_data !== 32'h8) begin
            n_fail++;
            $display("FAIL b2b_pre_edge: got dbg=%h wb=%h expected dbg=5 wb=8",
                     dbg_data, wb_data);
        end
        exec(32'h2200_0003);
        exec(32'h6200_0000);
        rd(3'd0, v);
        n_checks++;
        if (v !== 32'h10) begin
            n_fail++;
            $display("FAIL b2b_chain: got %h expected %h", v, 32'h10);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        exec(32'h00C0_1234);
        rd(3'd3, v);
        n_checks++;
        if (v !== 32'h1234) begin
            n_fail++;
            $display("FAIL rst_load_R3: got %h expected %h", v, 32'h1234);
        end
        instruction = 32'h00C0_5678;
        dbg_addr = 3'd3;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dbg_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_async_R3: got %h expected %h", dbg_data, 32'h0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dbg_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_pending_R3: got %h expected %h", dbg_data, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exec(32'h0100_ABCD);
        rd(3'd4, v);
        n_checks++;
        if (v !== 32'hABCD) begin
            n_fail++;
            $display("FAIL rst_first_write_R4: got %h expected %h", v, 32'hABCD);
        end
        rd(3'd3, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_R3_after: got %h expected %h", v, 32'h0);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        instruction = 32'hE000_0000;
        dbg_addr    = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_move();
        test_clr_all();
        test_add_sub();
        test_logic();
        test_wrap();
        test_nop();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
